// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO and its downstream byte serializer.
package fifo_pkg;

    localparam int FIFO_DATA_W = 16;
    localparam int BYTE_W      = 8;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND_FIRST  = 2'd1,
        SEND_SECOND = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_byte_serializer.sv
// Pops 16-bit words from a show-ahead FIFO and streams them as valid/ready bytes,
// counting completed words.
module fifo_byte_serializer
    import fifo_pkg::*;
#(
    parameter int unsigned COUNT_W   = 16,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [FIFO_DATA_W-1:0] fifo_data,
    input  logic                   fifo_empty,
    input  logic                   fifo_full,
    input  logic                   fifo_wr_en,
    output logic                   fifo_rd_en,
    output logic [BYTE_W-1:0]      byte_out,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   byte_last,
    output logic [COUNT_W-1:0]     word_count
);

    state_t                 r_state;
    logic [FIFO_DATA_W-1:0] r_word;
    logic [COUNT_W-1:0]     r_count;

    logic                   w_pop_ok;
    logic                   w_second_done;
    logic                   w_pop;
    logic [BYTE_W-1:0]      w_first_byte;
    logic [BYTE_W-1:0]      w_second_byte;

    // A write in the same cycle wins inside the FIFO, so a pop then would be lost.
    assign w_pop_ok      = !fifo_empty && !(fifo_wr_en && !fifo_full);
    assign w_second_done = (r_state == SEND_SECOND) && byte_ready;
    assign w_pop         = rst_n && w_pop_ok && ((r_state == IDLE) || w_second_done);
    assign fifo_rd_en    = w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_word <= fifo_data;
            end
            if (w_second_done) begin
                r_count <= r_count + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_pop) r_state <= SEND_FIRST;
                end
                SEND_FIRST: begin
                    if (byte_ready) r_state <= SEND_SECOND;
                end
                SEND_SECOND: begin
                    if (byte_ready) r_state <= w_pop ? SEND_FIRST : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_first_byte  = MSB_FIRST ? r_word[15:8] : r_word[7:0];
    assign w_second_byte = MSB_FIRST ? r_word[7:0]  : r_word[15:8];

    assign byte_valid = (r_state != IDLE);
    assign byte_last  = (r_state == SEND_SECOND);
    assign byte_out   = (r_state == SEND_SECOND) ? w_second_byte : w_first_byte;
    assign word_count = r_count;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Directed bench: three serializer instances, each fed by a small behavioural FIFO
// where a write takes priority over a read in the same cycle.
module tb_fifo_byte_serializer;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;

    logic [15:0] d0 = '0, d1 = '0, d2 = '0;
    logic [15:0] wd0 = '0, wd1 = '0, wd2 = '0;
    logic        e0 = 1'b1, e1 = 1'b1, e2 = 1'b1;
    logic        f0 = 1'b0, f1 = 1'b0, f2 = 1'b0;
    logic        wr0 = 1'b0, wr1 = 1'b0, wr2 = 1'b0;
    logic        rd0, rd1, rd2;
    logic [7:0]  b0, b1, b2;
    logic        v0, v1, v2, l0, l1, l2;
    logic        rdy0 = 1'b0, rdy1 = 1'b1, rdy2 = 1'b1;
    logic [15:0] wc0, wc1;
    logic [1:0]  wc2;

    int total = 0;
    int bad   = 0;

    logic [15:0] q0[$], q1[$], q2[$];
    logic [8:0]  got0[$], got1[$];
    int          gcyc0[$];
    logic [1:0]  wclog2[$];
    int          cyc = 0;
    int          pops0 = 0;
    int          stab_err = 0;
    logic        hold_v = 1'b0;
    logic [8:0]  hold = '0;
    logic [1:0]  wc2_prev = '0;
    logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    fifo_byte_serializer #(.COUNT_W(16), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .fifo_data(d0), .fifo_empty(e0), .fifo_full(f0),
        .fifo_wr_en(wr0), .fifo_rd_en(rd0), .byte_out(b0), .byte_valid(v0),
        .byte_ready(rdy0), .byte_last(l0), .word_count(wc0));

    fifo_byte_serializer #(.COUNT_W(16), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .fifo_data(d1), .fifo_empty(e1), .fifo_full(f1),
        .fifo_wr_en(wr1), .fifo_rd_en(rd1), .byte_out(b1), .byte_valid(v1),
        .byte_ready(rdy1), .byte_last(l1), .word_count(wc1));

    fifo_byte_serializer #(.COUNT_W(2), .MSB_FIRST(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .fifo_data(d2), .fifo_empty(e2), .fifo_full(f2),
        .fifo_wr_en(wr2), .fifo_rd_en(rd2), .byte_out(b2), .byte_valid(v2),
        .byte_ready(rdy2), .byte_last(l2), .word_count(wc2));

    always #5 clk = ~clk;

    // FIFO models (depth 8) plus transfer logging for u0/u1.
    always @(posedge clk) begin
        if (wr0 && q0.size() < 8) q0.push_back(wd0);
        else if (rd0 && q0.size() > 0) void'(q0.pop_front());
        if (wr1 && q1.size() < 8) q1.push_back(wd1);
        else if (rd1 && q1.size() > 0) void'(q1.pop_front());
        if (wr2 && q2.size() < 8) q2.push_back(wd2);
        else if (rd2 && q2.size() > 0) void'(q2.pop_front());
        e0 <= (q0.size() == 0); f0 <= (q0.size() >= 8); d0 <= (q0.size() > 0) ? q0[0] : 16'h0;
        e1 <= (q1.size() == 0); f1 <= (q1.size() >= 8); d1 <= (q1.size() > 0) ? q1[0] : 16'h0;
        e2 <= (q2.size() == 0); f2 <= (q2.size() >= 8); d2 <= (q2.size() > 0) ? q2[0] : 16'h0;

        cyc <= cyc + 1;
        if (v0 && rdy0) begin
            got0.push_back({l0, b0});
            gcyc0.push_back(cyc);
        end
        if (v1 && rdy1) got1.push_back({l1, b1});
        if (rd0) pops0 <= pops0 + 1;

        // Once valid, the presented byte must not change or drop until accepted.
        if (v0) begin
            if (hold_v && ({l0, b0} !== hold)) stab_err <= stab_err + 1;
            hold_v <= !rdy0;
            hold   <= {l0, b0};
        end else begin
            if (hold_v) stab_err <= stab_err + 1;
            hold_v <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (wc2 !== wc2_prev) wclog2.push_back(wc2);
        wc2_prev <= wc2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cnt(input int which);
        if (which == 0) return got0.size();
        if (which == 1) return got1.size();
        return wclog2.size();
    endfunction

    task automatic wait_for(input int which, input int need, input int budget,
                            input bit toggle, input string tag);
        int n = 0;
        while (cnt(which) < need && n < budget) begin
            @(negedge clk);
            if (toggle) rdy0 = pat[n % 4];
            n++;
        end
        chk(tag, 32'(cnt(which) >= need), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic write4();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr0 = 1'b1;
            wd0 = {8'(2 * i + 1), 8'(2 * i + 2)};
            #1 chk("no_pop_during_write", 32'(rd0), 32'd0);
        end
        @(negedge clk);
        wr0 = 1'b0;
        #1 chk("pop_when_write_drops", 32'(rd0), 32'd1);
    endtask

    task automatic check_seq8(input int base, input string tag);
        logic [8:0] e;
        int gaps;
        for (int k = 0; k < 8; k++) begin
            e = {(k % 2 == 1), 8'(k + 1)};
            chk(tag, 32'(got0[base + k]), 32'(e));
        end
        gaps = 0;
        for (int k = 1; k < 8; k++)
            if (gcyc0[base + k] - gcyc0[base + k - 1] != 1) gaps++;
        if (tag == "seq_full_rate") chk("no_gap", 32'(gaps), 32'd0);
    endtask

    initial begin
        int base, base1, pbase, s0;

        #1 rst_n = 1'b0;
        rdy0 = 1'b1;

        // Load a word while held in reset: no pop may be issued.
        @(negedge clk); wr0 = 1'b1; wd0 = 16'hA5C3;
        @(negedge clk); wr0 = 1'b0;
        #1;
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_last", 32'(l0), 32'd0);
        chk("rst_byte", 32'(b0), 32'd0);
        chk("rst_count", 32'(wc0), 32'd0);
        chk("rst_rd_en", 32'(rd0), 32'd0);

        base = got0.size(); pbase = pops0;
        @(negedge clk); rst_n = 1'b1;
        wait_for(0, base + 2, 20, 1'b0, "single_word_wait");
        chk("single_b0", 32'(got0[base]), 32'h0A5);
        chk("single_b1", 32'(got0[base + 1]), 32'h1C3);
        chk("single_pops", 32'(pops0 - pbase), 32'd1);
        chk("single_count", 32'(wc0), 32'd1);
        chk("single_idle", 32'(v0), 32'd0);

        // u1 (LSB first) and u2 (2-bit counter) in parallel.
        base1 = got1.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr2 = 1'b1; wd2 = 16'(i);
            wr1 = (i == 0); wd1 = 16'hBEEF;
        end
        @(negedge clk); wr1 = 1'b0; wr2 = 1'b0;
        wait_for(2, 5, 60, 1'b0, "wrap_wait");
        wait_for(1, base1 + 2, 20, 1'b0, "lsb_wait");
        chk("lsb_b0", 32'(got1[base1]), 32'h0EF);
        chk("lsb_b1", 32'(got1[base1 + 1]), 32'h1BE);
        chk("wrap_0", 32'(wclog2[0]), 32'd1);
        chk("wrap_1", 32'(wclog2[1]), 32'd2);
        chk("wrap_2", 32'(wclog2[2]), 32'd3);
        chk("wrap_3", 32'(wclog2[3]), 32'd0);
        chk("wrap_4", 32'(wclog2[4]), 32'd1);

        // Four words written back-to-back, then drained at full rate.
        do_reset();
        rdy0 = 1'b1;
        base = got0.size(); pbase = pops0;
        write4();
        wait_for(0, base + 8, 40, 1'b0, "full_rate_wait");
        check_seq8(base, "seq_full_rate");
        chk("full_rate_pops", 32'(pops0 - pbase), 32'd4);
        chk("full_rate_count", 32'(wc0), 32'd4);

        // Same words with a stalling consumer.
        do_reset();
        rdy0 = 1'b1;
        base = got0.size(); pbase = pops0; s0 = stab_err;
        write4();
        wait_for(0, base + 8, 80, 1'b1, "stall_wait");
        check_seq8(base, "seq_stall");
        chk("stall_stable", 32'(stab_err - s0), 32'd0);
        chk("stall_pops", 32'(pops0 - pbase), 32'd4);
        chk("stall_count", 32'(wc0), 32'd4);

        // Reset while the second byte of a word is on the bus.
        do_reset();
        @(negedge clk); rdy0 = 1'b0; wr0 = 1'b1; wd0 = 16'hDEAD;
        @(negedge clk); wd0 = 16'hBEEF;
        @(negedge clk); wr0 = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_first_valid", 32'(v0), 32'd1);
        chk("mid_first_byte", 32'(b0), 32'hDE);
        rdy0 = 1'b1;
        @(negedge clk); rdy0 = 1'b0;
        #1;
        chk("mid_second_last", 32'(l0), 32'd1);
        chk("mid_second_byte", 32'(b0), 32'hAD);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(v0), 32'd0);
        chk("mid_rst_last", 32'(l0), 32'd0);
        chk("mid_rst_byte", 32'(b0), 32'd0);
        chk("mid_rst_rd_en", 32'(rd0), 32'd0);
        @(negedge clk);
        @(negedge clk);
        base = got0.size(); pbase = pops0;
        rst_n = 1'b1; rdy0 = 1'b1;
        wait_for(0, base + 2, 20, 1'b0, "after_rst_wait");
        chk("after_rst_b0", 32'(got0[base]), 32'h0BE);
        chk("after_rst_b1", 32'(got0[base + 1]), 32'h1EF);
        chk("after_rst_pops", 32'(pops0 - pbase), 32'd1);
        chk("after_rst_count", 32'(wc0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
